// File: rtl/state_sequencer_if.sv
// Memory handshake between the sequencer and the memory port.
// The sequencer drives the request and write enable; memory answers with a ready strobe.
interface state_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/state_sequencer.sv
// Next-state logic for a 13-state one-hot instruction sequencer. The state register lives
// outside this block. This block also tracks memory waits, sticky error flags and a count of decoded instructions.
module state_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    preset,
  input  logic [12:0]             q,
  input  logic [1:0]              ir_op,
  input  logic [2:0]              ir_op2,
  input  logic [5:0]              ir_op3,
  input  logic                    ir_i,
  input  logic                    cond_true,
  state_sequencer_if.master       mem,
  output logic [12:0]             d,
  output logic                    timeout_err,
  output logic                    illegal_op_err,
  output logic                    illegal_state_err,
  output logic [15:0]             instr_count
);

  typedef enum logic [12:0] {
    S_IF       = 13'h0001,
    S_ID       = 13'h0002,
    S_ALU_RR   = 13'h0004,
    S_ALU_RI   = 13'h0008,
    S_LD_ADDR  = 13'h0010,
    S_LD_MEM   = 13'h0020,
    S_ST_ADDR  = 13'h0040,
    S_ST_MEM   = 13'h0080,
    S_BR_EVAL  = 13'h0100,
    S_BR_TAKEN = 13'h0200,
    S_CALL     = 13'h0400,
    S_JMPL     = 13'h0800,
    S_SETHI    = 13'h1000
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  logic [3:0]  wait_cnt_reg;
  logic        timeout_err_reg;
  logic        illegal_op_err_reg;
  logic        illegal_state_err_reg;
  logic [15:0] instr_count_reg;

  logic wait_inc;
  logic timeout_hit;
  logic bad_op;
  logic bad_state;

  always_comb begin
    d           = S_IF;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    wait_inc    = 1'b0;
    timeout_hit = 1'b0;
    bad_op      = 1'b0;
    bad_state   = 1'b0;
    // Exact-match case: any pattern that is not one-hot falls to default.
    case (q)
      S_IF, S_LD_MEM, S_ST_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (q == S_ST_MEM);
        if (mem.mem_ready)
          d = (q == S_IF) ? S_ID : S_IF;
        else if (wait_cnt_reg == WAIT_LAST)
          timeout_hit = 1'b1;
        else begin
          d        = q;
          wait_inc = 1'b1;
        end
      end
      S_ID: begin
        case (ir_op)
          2'b01: d = S_CALL;
          2'b00: begin
            if (ir_op2 == 3'b100)      d = S_SETHI;
            else if (ir_op2 == 3'b010) d = S_BR_EVAL;
            else                       bad_op = 1'b1;
          end
          2'b10: begin
            if (ir_op3 == 6'b111000) d = S_JMPL;
            else if (ir_i)           d = S_ALU_RI;
            else                     d = S_ALU_RR;
          end
          default: begin
            if (ir_op3 == 6'b000000)      d = S_LD_ADDR;
            else if (ir_op3 == 6'b000100) d = S_ST_ADDR;
            else                          bad_op = 1'b1;
          end
        endcase
      end
      S_LD_ADDR: d = S_LD_MEM;
      S_ST_ADDR: d = S_ST_MEM;
      S_BR_EVAL: d = cond_true ? S_BR_TAKEN : S_IF;
      S_ALU_RR, S_ALU_RI, S_SETHI, S_CALL, S_JMPL, S_BR_TAKEN: d = S_IF;
      default: bad_state = 1'b1;
    endcase
    if (preset)
      d = S_IF;
  end

  // Every non-holding cycle leaves the current state, so wait_cnt clears whenever it is not counting.
  always_ff @(posedge clk) begin
    if (preset) begin
      wait_cnt_reg          <= 4'd0;
      timeout_err_reg       <= 1'b0;
      illegal_op_err_reg    <= 1'b0;
      illegal_state_err_reg <= 1'b0;
      instr_count_reg       <= 16'd0;
    end else begin
      wait_cnt_reg <= wait_inc ? wait_cnt_reg + 4'd1 : 4'd0;
      if (timeout_hit) timeout_err_reg       <= 1'b1;
      if (bad_op)      illegal_op_err_reg    <= 1'b1;
      if (bad_state)   illegal_state_err_reg <= 1'b1;
      if (q == S_ID)   instr_count_reg       <= instr_count_reg + 16'd1;
    end
  end

  assign timeout_err       = timeout_err_reg;
  assign illegal_op_err    = illegal_op_err_reg;
  assign illegal_state_err = illegal_state_err_reg;
  assign instr_count       = instr_count_reg;

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer (TIMEOUT=4); the bench models the external state register,
// with an override for forcing q.
module tb_state_sequencer;
  localparam logic [12:0] S_IF = 13'h0001, S_ID = 13'h0002, S_ALU_RR = 13'h0004,
    S_ALU_RI = 13'h0008, S_LD_ADDR = 13'h0010, S_LD_MEM = 13'h0020, S_ST_ADDR = 13'h0040,
    S_ST_MEM = 13'h0080, S_BR_EVAL = 13'h0100, S_BR_TAKEN = 13'h0200, S_CALL = 13'h0400,
    S_JMPL = 13'h0800, S_SETHI = 13'h1000;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic [12:0] q, q_reg = 13'd0, q_force = 13'd0;
  logic        force_en = 1'b0;
  logic [1:0]  ir_op = 2'b00;
  logic [2:0]  ir_op2 = 3'b000;
  logic [5:0]  ir_op3 = 6'b000000;
  logic        ir_i = 1'b0;
  logic        cond_true = 1'b0;
  logic [12:0] d;
  logic        timeout_err, illegal_op_err, illegal_state_err;
  logic [15:0] instr_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_count = 16'd0;

  state_sequencer_if mem_bus ();

  state_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .preset(preset), .q(q), .ir_op(ir_op), .ir_op2(ir_op2), .ir_op3(ir_op3),
    .ir_i(ir_i), .cond_true(cond_true), .mem(mem_bus), .d(d), .timeout_err(timeout_err),
    .illegal_op_err(illegal_op_err), .illegal_state_err(illegal_state_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) q_reg <= d;
  assign q = force_en ? q_force : q_reg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1; mem_bus.mem_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (d !== S_IF) begin n_bad++; $display("FAIL reset_d: got %h want %h", d, S_IF); end
    n_cmp++; if (q !== S_IF) begin n_bad++; $display("FAIL reset_q: got %h want %h", q, S_IF); end
    n_cmp++; if ({timeout_err, illegal_op_err, illegal_state_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {timeout_err, illegal_op_err, illegal_state_err}); end
    n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    preset = 1'b0;
    #1;
    n_cmp++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_memreq: got req=%b we=%b want req=1 we=0", mem_bus.mem_req, mem_bus.mem_we); end
    n_cmp++; if (d !== S_IF) begin n_bad++; $display("FAIL reset_hold: got %h want %h", d, S_IF); end
    $display("test_reset done");
  endtask

  task automatic test_fetch();
    mem_bus.mem_ready = 1'b1; ir_op = 2'b10; ir_op3 = 6'b000000; ir_i = 1'b1;
    #1;
    n_cmp++; if (d !== S_ID) begin n_bad++; $display("FAIL fetch_if_d: got %h want %h", d, S_ID); end
    tick(); exp_count++;
    n_cmp++; if (q !== S_ID || mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_id: got q=%h req=%b want q=%h req=0", q, mem_bus.mem_req, S_ID); end
    n_cmp++; if (d !== S_ALU_RI) begin n_bad++; $display("FAIL fetch_decode: got %h want %h", d, S_ALU_RI); end
    tick();
    n_cmp++; if (q !== S_ALU_RI || d !== S_IF) begin n_bad++; $display("FAIL fetch_alu: got q=%h d=%h want q=%h d=%h", q, d, S_ALU_RI, S_IF); end
    n_cmp++; if (instr_count !== 16'd1) begin n_bad++; $display("FAIL fetch_count: got %0d want 1", instr_count); end
    tick();
    n_cmp++; if (q !== S_IF) begin n_bad++; $display("FAIL fetch_back: got %h want %h", q, S_IF); end
    $display("test_fetch done");
  endtask

  task automatic test_load_wait();
    mem_bus.mem_ready = 1'b1; ir_op = 2'b11; ir_op3 = 6'b000000;
    tick(); exp_count++;
    tick();
    n_cmp++; if (q !== S_LD_ADDR || d !== S_LD_MEM) begin n_bad++; $display("FAIL ld_addr: got q=%h d=%h want q=%h d=%h", q, d, S_LD_ADDR, S_LD_MEM); end
    tick();
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (q !== S_LD_MEM || d !== S_LD_MEM || mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL ld_wait%0d: got q=%h d=%h req=%b we=%b want q=d=%h req=1 we=0", i, q, d, mem_bus.mem_req, mem_bus.mem_we, S_LD_MEM); end
      tick();
    end
    n_cmp++; if (q !== S_LD_MEM || dut.wait_cnt_reg !== 4'd3) begin n_bad++; $display("FAIL ld_fourth: got q=%h wait=%0d want q=%h wait=3", q, dut.wait_cnt_reg, S_LD_MEM); end
    mem_bus.mem_ready = 1'b1;
    #1;
    n_cmp++; if (d !== S_IF) begin n_bad++; $display("FAIL ld_ready_at_limit: got %h want %h", d, S_IF); end
    tick();
    n_cmp++; if (q !== S_IF || timeout_err !== 1'b0 || dut.wait_cnt_reg !== 4'd0) begin n_bad++; $display("FAIL ld_done: got q=%h terr=%b wait=%0d want q=%h terr=0 wait=0", q, timeout_err, dut.wait_cnt_reg, S_IF); end
    $display("test_load_wait done");
  endtask

  task automatic test_store_timeout();
    mem_bus.mem_ready = 1'b1; ir_op = 2'b11; ir_op3 = 6'b000100;
    tick(); exp_count++;
    tick(); tick();
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (q !== S_ST_MEM || mem_bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL st_wait%0d: got q=%h we=%b want q=%h we=1", i, q, mem_bus.mem_we, S_ST_MEM); end
      if (i == 3) begin
        n_cmp++; if (d !== S_IF || timeout_err !== 1'b0) begin n_bad++; $display("FAIL st_abort_d: got d=%h terr=%b want d=%h terr=0", d, timeout_err, S_IF); end
      end
      tick();
    end
    n_cmp++; if (q !== S_IF || timeout_err !== 1'b1 || dut.wait_cnt_reg !== 4'd0) begin n_bad++; $display("FAIL st_timeout: got q=%h terr=%b wait=%0d want q=%h terr=1 wait=0", q, timeout_err, dut.wait_cnt_reg, S_IF); end
    mem_bus.mem_ready = 1'b1; ir_op = 2'b10; ir_op3 = 6'b000001; ir_i = 1'b0;
    tick(); exp_count++;
    n_cmp++; if (d !== S_ALU_RR) begin n_bad++; $display("FAIL alu_rr_decode: got %h want %h", d, S_ALU_RR); end
    tick(); tick();
    n_cmp++; if (q !== S_IF || timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got q=%h terr=%b want q=%h terr=1", q, timeout_err, S_IF); end
    $display("test_store_timeout done");
  endtask

  task automatic test_branch();
    mem_bus.mem_ready = 1'b1; ir_op = 2'b00; ir_op2 = 3'b010; cond_true = 1'b1;
    tick(); exp_count++;
    n_cmp++; if (d !== S_BR_EVAL) begin n_bad++; $display("FAIL br_decode: got %h want %h", d, S_BR_EVAL); end
    tick();
    n_cmp++; if (d !== S_BR_TAKEN) begin n_bad++; $display("FAIL br_taken_d: got %h want %h", d, S_BR_TAKEN); end
    tick();
    n_cmp++; if (q !== S_BR_TAKEN || d !== S_IF) begin n_bad++; $display("FAIL br_taken: got q=%h d=%h want q=%h d=%h", q, d, S_BR_TAKEN, S_IF); end
    tick(); cond_true = 1'b0;
    tick(); exp_count++;
    tick();
    n_cmp++; if (q !== S_BR_EVAL || d !== S_IF) begin n_bad++; $display("FAIL br_not_taken: got q=%h d=%h want q=%h d=%h", q, d, S_BR_EVAL, S_IF); end
    tick();
    n_cmp++; if (q !== S_IF) begin n_bad++; $display("FAIL br_back: got %h want %h", q, S_IF); end
    $display("test_branch done");
  endtask

  task automatic test_decode();
    logic [1:0]  t_op  [5] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    logic [2:0]  t_op2 [5] = '{3'b000, 3'b100, 3'b100, 3'b000, 3'b100};
    logic [5:0]  t_op3 [5] = '{6'b000000, 6'b111000, 6'b000000, 6'b111000, 6'b000101};
    logic        t_i   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [12:0] t_exp [5] = '{S_CALL, S_CALL, S_SETHI, S_JMPL, S_ALU_RI};
    mem_bus.mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ir_op = t_op[k]; ir_op2 = t_op2[k]; ir_op3 = t_op3[k]; ir_i = t_i[k];
      tick(); exp_count++;
      n_cmp++; if (d !== t_exp[k]) begin n_bad++; $display("FAIL decode%0d: got %h want %h", k, d, t_exp[k]); end
      tick();
      n_cmp++; if (d !== S_IF || illegal_op_err !== 1'b0) begin n_bad++; $display("FAIL decode%0d_exit: got d=%h ierr=%b want d=%h ierr=0", k, d, illegal_op_err, S_IF); end
      tick();
    end
    n_cmp++; if (instr_count !== exp_count) begin n_bad++; $display("FAIL decode_count: got %0d want %0d", instr_count, exp_count); end
    $display("test_decode done");
  endtask

  task automatic test_illegal();
    mem_bus.mem_ready = 1'b1; ir_op = 2'b11; ir_op3 = 6'b111111;
    tick(); exp_count++;
    n_cmp++; if (d !== S_IF || illegal_op_err !== 1'b0) begin n_bad++; $display("FAIL illop_d: got d=%h ierr=%b want d=%h ierr=0", d, illegal_op_err, S_IF); end
    tick();
    n_cmp++; if (q !== S_IF || illegal_op_err !== 1'b1) begin n_bad++; $display("FAIL illop_flag: got q=%h ierr=%b want q=%h ierr=1", q, illegal_op_err, S_IF); end
    q_force = 13'h003; force_en = 1'b1;
    #1;
    n_cmp++; if (d !== S_IF || mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL illstate_d: got d=%h req=%b want d=%h req=0", d, mem_bus.mem_req, S_IF); end
    tick();
    force_en = 1'b0;
    #1;
    n_cmp++; if (illegal_state_err !== 1'b1 || q !== S_IF || dut.wait_cnt_reg !== 4'd0) begin n_bad++; $display("FAIL illstate_flag: got serr=%b q=%h wait=%0d want serr=1 q=%h wait=0", illegal_state_err, q, dut.wait_cnt_reg, S_IF); end
    $display("test_illegal done");
  endtask

  task automatic test_reset_mid();
    mem_bus.mem_ready = 1'b1; ir_op = 2'b11; ir_op3 = 6'b000000;
    tick(); tick(); tick();
    mem_bus.mem_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (q !== S_LD_MEM || dut.wait_cnt_reg !== 4'd2) begin n_bad++; $display("FAIL mid_setup: got q=%h wait=%0d want q=%h wait=2", q, dut.wait_cnt_reg, S_LD_MEM); end
    preset = 1'b1;
    #1;
    n_cmp++; if (d !== S_IF) begin n_bad++; $display("FAIL mid_d: got %h want %h", d, S_IF); end
    tick();
    n_cmp++; if (q !== S_IF || dut.wait_cnt_reg !== 4'd0 || instr_count !== 16'd0) begin n_bad++; $display("FAIL mid_state: got q=%h wait=%0d cnt=%0d want q=%h wait=0 cnt=0", q, dut.wait_cnt_reg, instr_count, S_IF); end
    n_cmp++; if ({timeout_err, illegal_op_err, illegal_state_err} !== 3'b000) begin n_bad++; $display("FAIL mid_flags: got %b want 000", {timeout_err, illegal_op_err, illegal_state_err}); end
    preset = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    mem_bus.mem_ready = 1'b0;
    test_reset();
    test_fetch();
    test_load_wait();
    test_store_timeout();
    test_branch();
    test_decode();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
